// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard unit: MD FSM encoding,
// multiply/divide latency default and the register-match helper.
package hazard_ctrl_pkg;

    localparam int MD_LATENCY_DEF = 8;
    localparam int CNT_W          = 5;

    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    typedef logic [4:0] reg_addr_t;

    // A producer never hazards through $0, which is hardwired to zero.
    function automatic logic src_match(input reg_addr_t rs,
                                       input reg_addr_t rt,
                                       input logic      use_rs,
                                       input logic      use_rt,
                                       input reg_addr_t dst);
        return (dst != '0) && ((use_rs && (rs == dst)) || (use_rt && (rt == dst)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_timer.sv
// Tracks how long the multiply/divide unit owns HI/LO and pulses done
// for one cycle once the operation has drained.
module md_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF
) (
    input  logic clk,
    input  logic rst_i,
    input  logic start_i,
    output logic busy_o,
    output logic count_nz_o,
    output logic done_o
);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    state_d = MD_BUSY;
                    count_d = CNT_W'(MD_LATENCY - 1);
                end
            end
            default: begin
                if (count_q != '0) begin
                    count_d = count_q - CNT_W'(1);
                end else begin
                    state_d = MD_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MD_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign busy_o     = (state_q == MD_BUSY);
    assign count_nz_o = (count_q != '0);
    assign done_o     = done_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use, branch-operand and HI/LO interlocks,
// IF/ID flush gating and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic        use_rs,
    input  logic        use_rt,
    input  logic        id_branch,
    input  logic        id_uses_hilo,
    input  logic        ID_EX_RegWrite,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_WriteAddr,
    input  logic        EX_MEM_MemRead,
    input  logic [4:0]  EX_MEM_WriteAddr,
    input  logic        md_start,
    input  logic        branch_taken,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        ID_EX_Bubble,
    output logic        IF_ID_Flush,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cnt
);

    logic match_ex, match_mem;
    logic load_use, br_ex, br_mem, md_hold, stall;
    logic md_count_nz;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    md_timer #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_timer (
        .clk        (clk),
        .rst_i      (reset),
        .start_i    (md_start),
        .busy_o     (md_busy),
        .count_nz_o (md_count_nz),
        .done_o     (md_done)
    );

    assign match_ex  = src_match(rs, rt, use_rs, use_rt, ID_EX_WriteAddr);
    assign match_mem = src_match(rs, rt, use_rs, use_rt, EX_MEM_WriteAddr);

    // Branches resolve in ID, so even an ALU result in EX is too late for them.
    assign load_use = ID_EX_MemRead & match_ex;
    assign br_ex    = id_branch & ID_EX_RegWrite & match_ex;
    assign br_mem   = id_branch & EX_MEM_MemRead & match_mem;
    assign md_hold  = md_busy & md_count_nz & id_uses_hilo;
    assign stall    = load_use | br_ex | br_mem | md_hold;

    assign PC_Write     = ~stall;
    assign IF_ID_Write  = ~stall;
    assign ID_EX_Bubble = stall;
    assign IF_ID_Flush  = branch_taken & ~stall;

    assign stall_cnt_d = (stall && (stall_cnt_q != 16'hFFFF)) ? stall_cnt_q + 16'd1 : stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: a table of single-cycle
// hazard vectors plus hand-written multi-cycle sequences.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs, rt;
    logic        use_rs, use_rt, id_branch, id_uses_hilo;
    logic        ID_EX_RegWrite, ID_EX_MemRead;
    logic [4:0]  ID_EX_WriteAddr;
    logic        EX_MEM_MemRead;
    logic [4:0]  EX_MEM_WriteAddr;
    logic        md_start, branch_taken;
    logic        PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush;
    logic        md_busy, md_done;
    logic [15:0] stall_cnt;

    logic        pc_write2, if_id_write2, bubble2, flush2, md_busy2, md_done2;
    logic [15:0] stall_cnt2;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LATENCY(8)) dut (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .id_branch(id_branch), .id_uses_hilo(id_uses_hilo),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_WriteAddr(ID_EX_WriteAddr), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_WriteAddr(EX_MEM_WriteAddr), .md_start(md_start),
        .branch_taken(branch_taken), .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .ID_EX_Bubble(ID_EX_Bubble), .IF_ID_Flush(IF_ID_Flush),
        .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.MD_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .id_branch(id_branch), .id_uses_hilo(id_uses_hilo),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_WriteAddr(ID_EX_WriteAddr), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_WriteAddr(EX_MEM_WriteAddr), .md_start(md_start),
        .branch_taken(branch_taken), .PC_Write(pc_write2), .IF_ID_Write(if_id_write2),
        .ID_EX_Bubble(bubble2), .IF_ID_Flush(flush2),
        .md_busy(md_busy2), .md_done(md_done2), .stall_cnt(stall_cnt2)
    );

    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       use_rs, use_rt, id_branch, id_uses_hilo;
        logic       idex_regwrite, idex_memread;
        logic [4:0] idex_wa;
        logic       exmem_memread;
        logic [4:0] exmem_wa;
        logic       taken;
        logic       exp_stall, exp_flush;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rs = '0; rt = '0; use_rs = 0; use_rt = 0; id_branch = 0; id_uses_hilo = 0;
        ID_EX_RegWrite = 0; ID_EX_MemRead = 0; ID_EX_WriteAddr = '0;
        EX_MEM_MemRead = 0; EX_MEM_WriteAddr = '0; md_start = 0; branch_taken = 0;
    endtask

    // Inputs already applied after a falling edge; checks controls, then the counter after the rise.
    task automatic cycle_check(input string tag, input logic exp_stall, input logic exp_flush);
        #1;
        check({tag, ".PC_Write"},     PC_Write,     !exp_stall);
        check({tag, ".IF_ID_Write"},  IF_ID_Write,  !exp_stall);
        check({tag, ".ID_EX_Bubble"}, ID_EX_Bubble, exp_stall);
        check({tag, ".IF_ID_Flush"},  IF_ID_Flush,  exp_flush);
        @(posedge clk);
        #1;
        if (exp_stall) exp_cnt++;
        check({tag, ".stall_cnt"}, stall_cnt, exp_cnt);
    endtask

    initial begin
        //          name         rs rt urs urt br hilo rw mr wa mmr mwa tk  stall flush
        vecs[0]  = '{"idle",      0, 0, 0, 0, 0, 0,   0, 0, 0, 0,  0, 0,  0, 0};
        vecs[1]  = '{"load_use",  5, 0, 1, 0, 0, 0,   1, 1, 5, 0,  0, 0,  1, 0};
        vecs[2]  = '{"lu_unused", 5, 0, 0, 0, 0, 0,   1, 1, 5, 0,  0, 0,  0, 0};
        vecs[3]  = '{"lu_rt",     0, 7, 0, 1, 0, 0,   1, 1, 7, 0,  0, 0,  1, 0};
        vecs[4]  = '{"lu_r0",     0, 0, 1, 0, 0, 0,   1, 1, 0, 0,  0, 0,  0, 0};
        vecs[5]  = '{"lu_nomatch",6, 0, 1, 0, 0, 0,   1, 1, 5, 0,  0, 0,  0, 0};
        vecs[6]  = '{"br_ex",     9, 0, 1, 0, 1, 0,   1, 0, 9, 0,  0, 1,  1, 0};
        vecs[7]  = '{"alu_fwd",   9, 0, 1, 0, 0, 0,   1, 0, 9, 0,  0, 0,  0, 0};
        vecs[8]  = '{"br_mem",    0, 4, 0, 1, 1, 0,   0, 0, 0, 1,  4, 1,  1, 0};
        vecs[9]  = '{"mem_nobr",  0, 4, 0, 1, 0, 0,   0, 0, 0, 1,  4, 0,  0, 0};
        vecs[10] = '{"br_taken",  3, 2, 1, 1, 1, 0,   0, 0, 0, 0,  0, 1,  0, 1};
        vecs[11] = '{"br_mem_r0", 0, 0, 1, 0, 1, 0,   0, 0, 0, 1,  0, 1,  0, 1};
        vecs[12] = '{"hilo_idle", 0, 0, 0, 0, 0, 1,   0, 0, 0, 0,  0, 0,  0, 0};

        clear_inputs();
        reset = 1'b1;
        #2;
        check("rst.md_busy", md_busy, 0);
        check("rst.md_done", md_done, 0);
        check("rst.stall_cnt", stall_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst.PC_Write", PC_Write, 1);
        check("post_rst.IF_ID_Write", IF_ID_Write, 1);
        check("post_rst.ID_EX_Bubble", ID_EX_Bubble, 0);
        check("post_rst.IF_ID_Flush", IF_ID_Flush, 0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rs = vecs[i].rs; rt = vecs[i].rt;
            use_rs = vecs[i].use_rs; use_rt = vecs[i].use_rt;
            id_branch = vecs[i].id_branch; id_uses_hilo = vecs[i].id_uses_hilo;
            ID_EX_RegWrite = vecs[i].idex_regwrite; ID_EX_MemRead = vecs[i].idex_memread;
            ID_EX_WriteAddr = vecs[i].idex_wa;
            EX_MEM_MemRead = vecs[i].exmem_memread; EX_MEM_WriteAddr = vecs[i].exmem_wa;
            branch_taken = vecs[i].taken;
            cycle_check(vecs[i].name, vecs[i].exp_stall, vecs[i].exp_flush);
        end

        // lw $8 followed by beq $8: two stall cycles, then the branch may flush.
        @(negedge clk);
        clear_inputs();
        id_branch = 1; rs = 8; use_rs = 1; branch_taken = 1;
        ID_EX_RegWrite = 1; ID_EX_MemRead = 1; ID_EX_WriteAddr = 8;
        cycle_check("lwbr.c1", 1, 0);
        @(negedge clk);
        ID_EX_RegWrite = 0; ID_EX_MemRead = 0; ID_EX_WriteAddr = 0;
        EX_MEM_MemRead = 1; EX_MEM_WriteAddr = 8;
        cycle_check("lwbr.c2", 1, 0);
        @(negedge clk);
        EX_MEM_MemRead = 0; EX_MEM_WriteAddr = 0;
        cycle_check("lwbr.c3", 0, 1);

        // Multiply, then mfhi waits in ID; a second start during BUSY is ignored.
        @(negedge clk);
        clear_inputs();
        md_start = 1;
        cycle_check("md.start", 0, 0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            md_start = (k == 3);
            id_uses_hilo = 1;
            #1;
            check($sformatf("md.c%0d.busy", k), md_busy, 1);
            check($sformatf("md.c%0d.done", k), md_done, 0);
            cycle_check($sformatf("md.c%0d", k), (k <= 7), 0);
        end
        @(negedge clk);
        md_start = 0;
        #1;
        check("md.c9.busy", md_busy, 0);
        check("md.c9.done", md_done, 1);
        cycle_check("md.c9", 0, 0);
        @(negedge clk);
        #1;
        check("md.c10.done", md_done, 0);

        // Reset in the third BUSY cycle abandons the operation silently.
        @(negedge clk);
        clear_inputs();
        md_start = 1;
        @(negedge clk);
        md_start = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("mdrst.busy_before", md_busy, 1);
        reset = 1'b1;
        #1;
        check("mdrst.busy", md_busy, 0);
        check("mdrst.done", md_done, 0);
        check("mdrst.stall_cnt", stall_cnt, 0);
        exp_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("mdrst.after%0d", k), {md_busy, md_done}, 2'b00);
        end

        // Minimum latency: BUSY for exactly two cycles.
        @(negedge clk);
        md_start = 1;
        @(negedge clk);
        md_start = 0;
        #1;
        check("lat2.c1.busy", md_busy2, 1);
        @(negedge clk);
        #1;
        check("lat2.c2.busy", md_busy2, 1);
        check("lat2.c2.done", md_done2, 0);
        @(negedge clk);
        #1;
        check("lat2.c3.busy", md_busy2, 0);
        check("lat2.c3.done", md_done2, 1);
        @(negedge clk);
        #1;
        check("lat2.c4.done", md_done2, 0);

        // Hold a load-use stall long enough to reach saturation.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        ID_EX_MemRead = 1; ID_EX_WriteAddr = 5; rs = 5; use_rs = 1;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check("sat.fffe", stall_cnt, 16'hFFFE);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("sat.ffff", stall_cnt, 16'hFFFF);
        check("sat.PC_Write", PC_Write, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
